// File: rtl/fibseq_pkg.sv
// fibseq_pkg: shared types and constants for the second-order recurrence
// generator (state encoding, seed selector codes, Lucas seeds).
package fibseq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SEED_FIB    = 2'b00;
    localparam logic [1:0] SEED_LUCAS  = 2'b01;
    localparam logic [1:0] SEED_CUSTOM = 2'b10;

    // Lucas sequence starts at L(0)=2, L(1)=1
    localparam int LUCAS_T0 = 2;
    localparam int LUCAS_T1 = 1;

endpackage

// File: rtl/fibseq_step.sv
// fibseq_step: one combinational advance of the recurrence window.
// (a, b) -> (b, a+b), carrying sticky overflow flags along with each term.
module fibseq_step #(
    parameter int F_WIDTH = 10
) (
    input  logic [F_WIDTH-1:0] a_i,
    input  logic [F_WIDTH-1:0] b_i,
    input  logic               a_c_i,
    input  logic               b_c_i,
    output logic [F_WIDTH-1:0] a_o,
    output logic [F_WIDTH-1:0] b_o,
    output logic               a_c_o,
    output logic               b_c_o
);

    logic [F_WIDTH:0] sum;

    // New term is the truncated sum; its flag is sticky from either parent
    // so an overflow anywhere earlier in the chain stays visible.
    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        a_o   = b_i;
        a_c_o = b_c_i;
        b_o   = sum[F_WIDTH-1:0];
        b_c_o = a_c_i | b_c_i | sum[F_WIDTH];
    end

endmodule

// File: rtl/fibseq_gen.sv
// fibseq_gen: computes T(n) of T(k+2)=T(k+1)+T(k) with Fibonacci, Lucas or
// custom seeds behind a start/done handshake.
// Optional macro FIBSEQ_STREAM_EN adds a per-term output stream (term,
// term_valid) emitting T(0)..T(n) during the run.
module fibseq_gen
    import fibseq_pkg::*;
#(
    parameter int N_WIDTH = 4,
    parameter int F_WIDTH = 2*N_WIDTH+2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    input  logic [1:0]         seed_sel,
    input  logic [F_WIDTH-1:0] seed0,
    input  logic [F_WIDTH-1:0] seed1,
    output logic               busy,
    output logic               done,
    output logic [F_WIDTH-1:0] f,
`ifdef FIBSEQ_STREAM_EN
    output logic [F_WIDTH-1:0] term,
    output logic               term_valid,
`endif
    output logic               ovf
);

    state_e             state_q, state_d;
    logic [F_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic               a_c_q, a_c_d, b_c_q, b_c_d;
    logic [N_WIDTH-1:0] k_q, k_d, n_q, n_d;
    logic               busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [F_WIDTH-1:0] f_q, f_d;
`ifdef FIBSEQ_STREAM_EN
    logic [F_WIDTH-1:0] term_q, term_d;
    logic               term_valid_q, term_valid_d;
`endif

    logic [F_WIDTH-1:0] a_nxt, b_nxt;
    logic               a_c_nxt, b_c_nxt;

    fibseq_step #(.F_WIDTH(F_WIDTH)) u_step (
        .a_i   (a_q),
        .b_i   (b_q),
        .a_c_i (a_c_q),
        .b_c_i (b_c_q),
        .a_o   (a_nxt),
        .b_o   (b_nxt),
        .a_c_o (a_c_nxt),
        .b_c_o (b_c_nxt)
    );

    // Next-state logic: accept in IDLE, step or finish in RUN. The result is
    // taken from a (T(n)), so the carry produced by T(n+1) only lands in b_c
    // and never reaches ovf.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_c_d   = a_c_q;
        b_c_d   = b_c_q;
        k_d     = k_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        f_d     = f_q;
        ovf_d   = ovf_q;
`ifdef FIBSEQ_STREAM_EN
        term_d       = term_q;
        term_valid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    n_d     = n;
                    k_d     = '0;
                    a_c_d   = 1'b0;
                    b_c_d   = 1'b0;
                    busy_d  = 1'b1;
                    case (seed_sel)
                        SEED_LUCAS: begin
                            a_d = F_WIDTH'(LUCAS_T0);
                            b_d = F_WIDTH'(LUCAS_T1);
                        end
                        SEED_CUSTOM: begin
                            a_d = seed0;
                            b_d = seed1;
                        end
                        default: begin
                            a_d = '0;
                            b_d = F_WIDTH'(1);
                        end
                    endcase
                end
            end
            RUN: begin
`ifdef FIBSEQ_STREAM_EN
                term_d       = a_q;
                term_valid_d = 1'b1;
`endif
                if (k_q == n_q) begin
                    f_d     = a_q;
                    ovf_d   = a_c_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    a_d   = a_nxt;
                    b_d   = b_nxt;
                    a_c_d = a_c_nxt;
                    b_c_d = b_c_nxt;
                    k_d   = k_q + N_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also aborts an in-flight run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_c_q   <= 1'b0;
            b_c_q   <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef FIBSEQ_STREAM_EN
            term_q       <= '0;
            term_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_c_q   <= a_c_d;
            b_c_q   <= b_c_d;
            k_q     <= k_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            f_q     <= f_d;
            ovf_q   <= ovf_d;
`ifdef FIBSEQ_STREAM_EN
            term_q       <= term_d;
            term_valid_q <= term_valid_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign f    = f_q;
    assign ovf  = ovf_q;
`ifdef FIBSEQ_STREAM_EN
    assign term       = term_q;
    assign term_valid = term_valid_q;
`endif

endmodule

// File: tb/tb_fibseq_gen.sv
// tb_fibseq_gen: directed and random runs of fibseq_gen checked against an
// arithmetic model of the recurrence. Covers the stream ports when
// FIBSEQ_STREAM_EN is defined.
module tb_fibseq_gen;

    localparam int NW = 4;
    localparam int FW = 2*NW+2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n = '0;
    logic [1:0]    seed_sel = '0;
    logic [FW-1:0] seed0 = '0;
    logic [FW-1:0] seed1 = '0;
    logic          busy, done, ovf;
    logic [FW-1:0] f;
`ifdef FIBSEQ_STREAM_EN
    logic [FW-1:0] term;
    logic          term_valid;
`endif

    int vectors = 0;
    int miscompares = 0;

    // model results for the run in flight
    logic [FW-1:0] exp_f;
    logic          exp_ovf;
    logic [FW-1:0] exp_seq[$];

    fibseq_gen #(.N_WIDTH(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .seed_sel   (seed_sel),
        .seed0      (seed0),
        .seed1      (seed1),
        .busy       (busy),
        .done       (done),
        .f          (f),
`ifdef FIBSEQ_STREAM_EN
        .term       (term),
        .term_valid (term_valid),
`endif
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

`define CHK(tag, obs, exp) \
    begin \
        vectors++; \
        assert ((obs) === (exp)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
        end \
    end

    // Exact (unbounded) recurrence; overflow if any of T(0)..T(nn) >= 2^FW.
    task automatic model(input int nn, input int sel, input int s0, input int s1);
        longint t0, t1, tn;
        longint lim = longint'(1) << FW;
        exp_seq = {};
        exp_ovf = 1'b0;
        case (sel)
            1:       begin t0 = 2;  t1 = 1;  end
            2:       begin t0 = s0; t1 = s1; end
            default: begin t0 = 0;  t1 = 1;  end
        endcase
        for (int j = 0; j <= nn; j++) begin
            exp_seq.push_back(FW'(t0 % lim));
            if (t0 >= lim) exp_ovf = 1'b1;
            tn = t0 + t1;
            t0 = t1;
            t1 = tn;
        end
        exp_f = exp_seq[nn];
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    // Inputs are scrambled right after acceptance.
    task automatic launch(input int nn, input int sel, input int s0, input int s1);
        start    = 1'b1;
        n        = NW'(nn);
        seed_sel = 2'(sel);
        seed0    = FW'(s0);
        seed1    = FW'(s1);
        model(nn, sel, s0, s1);
        @(negedge clk);
        start    = 1'b0;
        n        = NW'($urandom);
        seed_sel = 2'($urandom);
        seed0    = FW'($urandom);
        seed1    = FW'($urandom);
    endtask

    // Starts one cycle after accept; returns at the negedge of the done cycle.
    task automatic finish_chk(input string tag, input int nn, input int pulse_at);
        int lat = 0;
        int busy_bad = 0;
        logic tv_at_done = 1'b0;
        logic [FW-1:0] got[$];
        `CHK({tag, "_done_low"}, done, 1'b0)
        while (1) begin
`ifdef FIBSEQ_STREAM_EN
            if (term_valid === 1'b1) got.push_back(term);
            tv_at_done = term_valid;
`endif
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad++;
            if (lat >= 40) break;
            start = (lat == pulse_at);
            if (lat == pulse_at) n = NW'(2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        `CHK({tag, "_latency"}, lat, nn + 1)
        `CHK({tag, "_busy_run"}, busy_bad, 0)
        `CHK({tag, "_busy_done"}, busy, 1'b0)
        `CHK({tag, "_f"}, f, exp_f)
        `CHK({tag, "_ovf"}, ovf, exp_ovf)
`ifdef FIBSEQ_STREAM_EN
        `CHK({tag, "_tv_at_done"}, tv_at_done, 1'b1)
        `CHK({tag, "_term_count"}, got.size(), exp_seq.size())
        for (int i = 0; i < got.size() && i < exp_seq.size(); i++)
            `CHK({tag, "_term"}, got[i], exp_seq[i])
`else
        if (tv_at_done) lat = lat;
`endif
    endtask

    initial begin
        int done_seen;
        int rn, rsel, rs0, rs1;

        // reset dominates start
        start = 1'b1;
        repeat (3) @(negedge clk);
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_f", f, 0)
        `CHK("rst_ovf", ovf, 1'b0)
`ifdef FIBSEQ_STREAM_EN
        `CHK("rst_tv", term_valid, 1'b0)
        `CHK("rst_term", term, 0)
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        launch(10, 0, 0, 0);  finish_chk("fib10", 10, -1);
        `CHK("fib10_const", f, 55)
        launch(15, 0, 0, 0);  finish_chk("fib15", 15, -1);
        `CHK("fib15_const", f, 610)
        @(negedge clk);
        launch(0, 1, 0, 0);   finish_chk("luc0", 0, -1);
        `CHK("luc0_const", f, 2)
        launch(14, 1, 0, 0);  finish_chk("luc14", 14, -1);
        `CHK("luc14_const", f, 843)
        launch(15, 1, 0, 0);  finish_chk("luc15", 15, -1);
        `CHK("luc15_const", f, 340)
        `CHK("luc15_ovf_const", ovf, 1'b1)
        launch(5, 2, 3, 4);   finish_chk("cust5", 5, -1);
        `CHK("cust5_const", f, 29)
        launch(7, 3, 0, 0);   finish_chk("rsv7", 7, -1);
        `CHK("rsv7_const", f, 13)
        launch(6, 0, 0, 0);   finish_chk("ignore", 6, 2);
        `CHK("ignore_const", f, 8)
        // back-to-back: accepted on the done cycle
        launch(3, 0, 0, 0);   finish_chk("b2b", 3, -1);
        `CHK("b2b_const", f, 2)
        launch(4, 0, 0, 0);   finish_chk("fib4", 4, -1);
        `CHK("fib4_const", f, 3)

        // abort at k=3 of n=10
        launch(10, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_f", f, 0)
        `CHK("abort_ovf", ovf, 1'b0)
`ifdef FIBSEQ_STREAM_EN
        `CHK("abort_tv", term_valid, 1'b0)
        `CHK("abort_term", term, 0)
`endif
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        `CHK("abort_no_done", done_seen, 0)

        // random runs with occasional idle gaps
        for (int it = 0; it < 30; it++) begin
            rn   = int'($urandom_range(0, (1 << NW) - 1));
            rsel = int'($urandom_range(0, 3));
            rs0  = int'($urandom_range(0, (1 << FW) - 1));
            rs1  = int'($urandom_range(0, (1 << FW) - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(rn, rsel, rs0, rs1);
            finish_chk("rand", rn, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
